apb_timer: RTL
==============

# apb_timer

APB slave peripheral that consumes the APB transfers produced by the `ahb2apb` bridge. It is a 32-bit down-counting timer with prescaler, auto-reload, sticky expiry flag and interrupt output, and a programmable number of APB wait states. It is the first real slave on the bridge's APB side and exercises `pready` stretching and `pslverr`.

## Interface
- `ADDR_WIDTH`, 32: APB address width; only `paddr_i[4:2]` is decoded.
- `DATA_WIDTH`, 32: APB data width; fixed at 32 for this block.
- `WAIT_STATES`, 1: access-phase cycles with `pready_o` low before completion; legal range 0..15.

Ports:
- `pclk_i` input 1: clock.
- `preset_i` input 1: reset, asynchronous, active-high.
- `psel_i` input 1: slave select.
- `penable_i` input 1: access phase.
- `pwrite_i` input 1: 1 = write, 0 = read.
- `paddr_i` input ADDR_WIDTH: byte address.
- `pwdata_i` input DATA_WIDTH: write data.
- `prdata_o` output DATA_WIDTH: read data; valid only while `pready_o` is 1, otherwise 0.
- `pready_o` output 1: transfer complete.
- `pslverr_o` output 1: error response; valid only while `pready_o` is 1.
- `irq_o` output 1: level interrupt, registered.

## Operation
- Register map (`paddr_i[4:2]`):
  - 0 CTRL, RW: bit0 EN, bit1 RELOAD, bit2 IRQ_EN.
  - 1 PRESCALE, RW, [15:0].
  - 2 LOAD, RW, 32 bits.
  - 3 COUNT, RO.
  - 4 STATUS: bit0 EXPIRED, write-1-to-clear.
  - 5..7 unmapped.
- Unused register bits read as 0.
- APB FSM has three states: IDLE, SETUP, ACCESS.
  - IDLE→SETUP when `psel_i & !penable_i`. On that edge, `wait_cnt` is loaded with WAIT_STATES.
  - SETUP→ACCESS unconditionally.
  - In ACCESS: `pready_o = psel_i & penable_i & (wait_cnt==0)`. While `wait_cnt != 0` it decrements each cycle.
  - ACCESS→IDLE on the `pready_o` cycle. If `psel_i` drops mid-access, go to IDLE with no side effect.
- Register writes and W1C take effect on the clock edge ending the `pready_o` cycle. Read data is muxed combinationally in that cycle.
- Prescaler `pre_cnt` (16 bits) runs while EN=1.
  - When `pre_cnt == PRESCALE`: tick, and `pre_cnt` goes to 0. Otherwise `pre_cnt` increments.
  - When EN=0, `pre_cnt` is held at 0.
- On each tick, COUNT is handled as follows:
  - COUNT != 0: COUNT decrements.
  - COUNT == 0: EXPIRED is set. If RELOAD=1, COUNT ← LOAD. If RELOAD=0, EN is cleared and COUNT stays at 0.
- A write to LOAD also writes COUNT and clears `pre_cnt`.
- `irq_o` is registered from `EXPIRED & IRQ_EN`.

Boundary rules:
- Expiry in the same cycle as a W1C of EXPIRED: set wins.
- LOAD write in the same cycle as a tick: the written value wins.
- CTRL write clearing EN in the same cycle as a tick: the tick is discarded.
- PRESCALE=0: one tick per cycle.
- LOAD=0 with RELOAD=1: expiry on every tick.
- Reset mid-transfer: everything returns to reset values immediately. The master sees `pready_o` = 0.

## Timing
- Reset values: `prdata_o` 0, `pready_o` 0, `pslverr_o` 0, `irq_o` 0. All registers, `pre_cnt` and `wait_cnt` are 0, and the FSM is in IDLE.
- Access latency: with setup at cycle T, `pready_o` goes high at cycle T+1+WAIT_STATES.
  - WAIT_STATES=0 gives a zero-wait APB transfer.
  - Back-to-back transfers are allowed. The setup phase may follow the `pready_o` cycle directly.
- With EN=1 and PRESCALE=P, COUNT changes every P+1 cycles. The first tick occurs P+1 cycles after the EN write edge.
- EXPIRED sets on the tick edge. `irq_o` rises one cycle later and falls one cycle after the W1C edge.

## Configuration
- `APB_TIMER_SLVERR_EN` defined:
  - `pslverr_o` = 1 in the `pready_o` cycle for an access to offsets 5..7 or a write to COUNT.
  - The access has no side effect.
  - Read data is 0.
- Macro undefined:
  - `pslverr_o` is tied to 0.
  - The same accesses are silently ignored and reads return 0.

## Test plan
- Reset, then read all five registers with WAIT_STATES=1 → each returns 0; `pready_o` rises exactly 2 cycles after setup; `irq_o` = 0.
- Write LOAD=3, PRESCALE=1, CTRL=0x7 → COUNT reads 3,2,1,0 at 2-cycle steps. Then EXPIRED=1, COUNT reloads to 3, and `irq_o` rises 1 cycle after expiry.
- CTRL=0x1 (no reload), LOAD=2, PRESCALE=0 → EXPIRED sets 3 cycles after the EN write; CTRL.EN reads 0; COUNT holds 0.
- Force a W1C of STATUS on the same edge as an expiry (LOAD=0, RELOAD=1, PRESCALE=0) → EXPIRED stays 1 and `irq_o` stays 1.
- With `APB_TIMER_SLVERR_EN` defined: write 0xDEAD to offset 0x0C and read offset 0x18 → `pslverr_o` = 1 on both, COUNT is unchanged, read data is 0. Without the macro: `pslverr_o` = 0 on both.
- Assert `preset_i` during the wait phase of a write to LOAD=0x55 → `pready_o` drops immediately and LOAD reads 0 after reset is released.

Source files
------------

// File: rtl/apb_timer.sv
// APB down-counting timer: prescaler, auto-reload, sticky expiry flag, IRQ, programmable wait states.
// Optional build macro APB_TIMER_SLVERR_EN enables pslverr_o for unmapped offsets and COUNT writes.
module apb_timer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  irq_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [3:0] WS        = 4'(WAIT_STATES);

  logic [1:0]            state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic                  en_q, en_d, reload_q, reload_d, irq_en_q, irq_en_d;
  logic [15:0]           prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic [DATA_WIDTH-1:0] load_q, load_d, count_q, count_d;
  logic                  expired_q, expired_d, irq_q, irq_d;

  logic                  pready, bad, wr, tick, tick_eff, expire_set;
  logic                  wr_ctrl, wr_prescale, wr_load, wr_status;
  logic [2:0]            off;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  unused_addr;

  assign unused_addr = ^{paddr_i[ADDR_WIDTH-1:5], paddr_i[1:0]};
  assign off         = paddr_i[4:2];

  // SETUP is the first access-phase cycle, so a zero-wait transfer completes there.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    pready     = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) &&
                 psel_i && penable_i && (wait_cnt_q == 4'd0);
    case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) begin
          state_d    = ST_SETUP;
          wait_cnt_d = WS;
        end
      end
      ST_SETUP, ST_ACCESS: begin
        if (!psel_i || pready) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end else begin
          state_d = ST_ACCESS;
          if (wait_cnt_q != 4'd0) wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  assign bad         = (off > 3'd4) || (pwrite_i && (off == 3'd3));
  assign wr          = pready && pwrite_i && !bad;
  assign wr_ctrl     = wr && (off == 3'd0);
  assign wr_prescale = wr && (off == 3'd1);
  assign wr_load     = wr && (off == 3'd2);
  assign wr_status   = wr && (off == 3'd4);

  always_comb begin
    rdata = '0;
    case (off)
      3'd0:    rdata = {{(DATA_WIDTH-3){1'b0}}, irq_en_q, reload_q, en_q};
      3'd1:    rdata = {{(DATA_WIDTH-16){1'b0}}, prescale_q};
      3'd2:    rdata = load_q;
      3'd3:    rdata = count_q;
      3'd4:    rdata = {{(DATA_WIDTH-1){1'b0}}, expired_q};
      default: rdata = '0;
    endcase
  end

  assign prdata_o = (pready && !pwrite_i && !bad) ? rdata : '0;
  assign pready_o = pready;
  assign irq_o    = irq_q;
`ifdef APB_TIMER_SLVERR_EN
  assign pslverr_o = pready && bad;
`else
  assign pslverr_o = 1'b0;
`endif

  // A CTRL write that clears EN discards a coinciding tick entirely.
  assign tick       = en_q && (pre_cnt_q == prescale_q);
  assign tick_eff   = tick && !(wr_ctrl && !pwdata_i[0]);
  assign expire_set = tick_eff && (count_q == '0);

  always_comb begin
    en_d       = en_q;
    reload_d   = reload_q;
    irq_en_d   = irq_en_q;
    prescale_d = prescale_q;
    load_d     = load_q;
    count_d    = count_q;
    pre_cnt_d  = (!en_q || tick) ? 16'd0 : pre_cnt_q + 16'd1;
    if (tick_eff) begin
      if (count_q != '0)  count_d = count_q - DATA_WIDTH'(1);
      else if (reload_q)  count_d = load_q;
      else                en_d    = 1'b0;
    end
    expired_d = (expired_q && !(wr_status && pwdata_i[0])) || expire_set;
    if (wr_ctrl) begin
      en_d     = pwdata_i[0];
      reload_d = pwdata_i[1];
      irq_en_d = pwdata_i[2];
    end
    if (wr_prescale) prescale_d = pwdata_i[15:0];
    if (wr_load) begin
      load_d    = pwdata_i;
      count_d   = pwdata_i;
      pre_cnt_d = 16'd0;
    end
    irq_d = expired_q && irq_en_q;
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      en_q       <= 1'b0;
      reload_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      prescale_q <= 16'd0;
      pre_cnt_q  <= 16'd0;
      load_q     <= '0;
      count_q    <= '0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      en_q       <= en_d;
      reload_q   <= reload_d;
      irq_en_q   <= irq_en_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      load_q     <= load_d;
      count_q    <= count_d;
      expired_q  <= expired_d;
      irq_q      <= irq_d;
    end
  end

endmodule
